// File: rtl/timer_pkg.sv
// Shared traffic-controller definitions used by the interval timer.
// Holds the default counter width and the timer state encoding.
package timer_pkg;

    localparam int unsigned TIMER_CNT_W = 4;

    typedef logic [TIMER_CNT_W-1:0] timer_cnt_t;

    typedef enum logic {
        TMR_IDLE,
        TMR_ARMED
    } timer_state_t;

endpackage

// File: rtl/timer_tick_detect.sv
// Rising-edge detector on the 1 Hz enable level: one tick per high phase.
// The history bit resets high so a level already high after reset is not a tick.
module timer_tick_detect (
    input  logic clk,
    input  logic Reset_Sync,
    input  logic oneHz_enable,
    output logic tick
);

    logic prev_en;

    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            prev_en <= 1'b1;
        end else begin
            prev_en <= oneHz_enable;
        end
    end

    assign tick = oneHz_enable & ~prev_en;

endmodule

// File: rtl/timer.sv
// Loadable down-counter of 1 Hz ticks; emits a registered one-cycle
// expired pulse on the Nth tick after a start_timer load.
module timer
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = TIMER_CNT_W
) (
    input  logic             clk,
    input  logic             Reset_Sync,
    input  logic [CNT_W-1:0] Value,
    input  logic             oneHz_enable,
    input  logic             start_timer,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_d;
    logic             tick;

    timer_tick_detect u_tick_detect (
        .clk          (clk),
        .Reset_Sync   (Reset_Sync),
        .oneHz_enable (oneHz_enable),
        .tick         (tick)
    );

    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            state_q <= TMR_IDLE;
            count_q <= '0;
            expired <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            expired <= expired_d;
        end
    end

    // A load wins over a coincident tick; count <= 1 also covers Value = 0.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
        if (start_timer) begin
            state_d = TMR_ARMED;
            count_d = Value;
        end else if (state_q == TMR_ARMED && tick) begin
            if (count_q > CNT_ONE) begin
                count_d = count_q - CNT_ONE;
            end else begin
                state_d   = TMR_IDLE;
                count_d   = '0;
                expired_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: a tick-counting reference model queues the
// expected expired value per edge; each is popped and checked at the negedge.
module tb_timer;

    logic       clk = 1'b0;
    logic       Reset_Sync;
    logic [3:0] Value;
    logic       oneHz_enable;
    logic       start_timer;
    logic       expired;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic exp_q[$];
    bit   m_prev;
    bit   m_armed;
    int   m_rem;
    int   pulses;
    int   pulse_off;
    string scen;

    timer #(.CNT_W(4)) dut (
        .clk          (clk),
        .Reset_Sync   (Reset_Sync),
        .Value        (Value),
        .oneHz_enable (oneHz_enable),
        .start_timer  (start_timer),
        .expired      (expired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_prev  = 1'b1;
        m_armed = 1'b0;
        m_rem   = 0;
        exp_q.delete();
    endtask

    // Drive one edge's inputs, predict, then compare after the edge.
    task automatic step(input bit en, input bit st, input logic [3:0] v, input int idx);
        bit   m_tick;
        logic e;
        logic got;
        oneHz_enable = en;
        start_timer  = st;
        Value        = v;
        m_tick = en && !m_prev;
        e = 1'b0;
        if (st) begin
            m_armed = 1'b1;
            m_rem   = (v == 4'd0) ? 1 : int'(v);
        end else if (m_armed && m_tick) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_armed = 1'b0;
                e = 1'b1;
            end
        end
        m_prev = en;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s scoreboard empty at step %0d", scen, idx);
        end else begin
            e = exp_q.pop_front();
            got = expired;
            assert (got === e) else begin
                n_fail++;
                $error("FAIL %s expired step %0d: got %b expected %b", scen, idx, got, e);
            end
        end
        if (expired === 1'b1) begin
            pulses++;
            pulse_off = idx;
        end
    endtask

    task automatic run_seq(input int n, input int hi, input int lo, input bit en0,
                           input bit do_start, input logic [3:0] v_load,
                           input int rs_c, input logic [3:0] v_rs,
                           input int chg_c, input logic [3:0] v_chg);
        bit         en;
        bit         st;
        logic [3:0] v;
        pulses    = 0;
        pulse_off = -1;
        for (int c = 0; c < n; c++) begin
            en = (c == 0) ? en0 : (((c - 1) % (hi + lo)) >= lo);
            st = (c == 0 && do_start) || (c == rs_c);
            v  = (c == rs_c) ? v_rs : ((c >= chg_c) ? v_chg : v_load);
            step(en, st, v, c);
        end
    endtask

    task automatic check_pulses(input int exp_n, input int exp_off);
        n_tests++;
        assert (pulses === exp_n) else begin
            n_fail++;
            $error("FAIL %s pulse count: got %0d expected %0d", scen, pulses, exp_n);
        end
        n_tests++;
        assert (pulse_off === exp_off) else begin
            n_fail++;
            $error("FAIL %s pulse step: got %0d expected %0d", scen, pulse_off, exp_off);
        end
    endtask

    // Reset pulse confined between two clock edges.
    task automatic async_reset();
        logic got;
        #1 Reset_Sync = 1'b1;
        #1;
        got = expired;
        n_tests++;
        assert (got === 1'b0) else begin
            n_fail++;
            $error("FAIL %s async reset: got %b expected 0", scen, got);
        end
        model_reset();
        #1 Reset_Sync = 1'b0;
    endtask

    initial begin
        logic got;
        Reset_Sync   = 1'b1;
        oneHz_enable = 1'b0;
        start_timer  = 1'b0;
        Value        = 4'd0;
        model_reset();
        scen = "reset";
        #2;
        got = expired;
        n_tests++;
        assert (got === 1'b0) else begin
            n_fail++;
            $error("FAIL reset expired: got %b expected 0", got);
        end
        repeat (2) @(negedge clk);
        Reset_Sync = 1'b0;

        // Enable already high after reset must not tick until it falls and rises.
        scen = "post_reset_high";
        pulses = 0;
        pulse_off = -1;
        step(1, 1, 4'd1, 0);
        step(1, 0, 4'd0, 1);
        step(1, 0, 4'd0, 2);
        step(1, 0, 4'd0, 3);
        step(0, 0, 4'd0, 4);
        step(1, 0, 4'd0, 5);
        step(1, 0, 4'd0, 6);
        step(0, 0, 4'd0, 7);
        step(1, 0, 4'd0, 8);
        check_pulses(1, 5);

        scen = "v6_2h2l";
        run_seq(28, 2, 2, 0, 1, 4'd6, -1, 4'd0, 1000, 4'd0);
        check_pulses(1, 23);

        scen = "v3_4h4l";
        run_seq(30, 4, 4, 0, 1, 4'd3, -1, 4'd0, 1000, 4'd0);
        check_pulses(1, 21);

        scen = "value_change";
        run_seq(28, 2, 2, 0, 1, 4'd6, -1, 4'd0, 8, 4'd8);
        check_pulses(1, 23);

        scen = "restart";
        run_seq(28, 2, 2, 0, 1, 4'd6, 12, 4'd2, 1000, 4'd0);
        check_pulses(1, 19);

        scen = "value0";
        run_seq(12, 2, 2, 0, 1, 4'd0, -1, 4'd0, 1000, 4'd0);
        check_pulses(1, 3);

        scen = "start_on_tick";
        step(0, 0, 4'd0, -1);
        run_seq(16, 2, 2, 1, 1, 4'd2, -1, 4'd0, 1000, 4'd0);
        check_pulses(1, 7);

        scen = "reset_in_pulse";
        run_seq(4, 2, 2, 0, 1, 4'd1, -1, 4'd0, 1000, 4'd0);
        check_pulses(1, 3);
        async_reset();

        scen = "reset_mid_count";
        run_seq(9, 2, 2, 0, 1, 4'd6, -1, 4'd0, 1000, 4'd0);
        check_pulses(0, -1);
        async_reset();
        run_seq(24, 2, 2, 0, 0, 4'd6, -1, 4'd0, 1000, 4'd0);
        check_pulses(0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
